// File: rtl/retire_trace_buffer_if.sv
// Bundle of capture inputs, drain handshake and status for retire_trace_buffer.
// The master drives the pipeline taps and the consumer ready.
// The slave is the trace unit.
interface retire_trace_buffer_if #(
    parameter int XLEN  = 32,
    parameter int CYC_W = 16
);
    logic             arm;
    logic [XLEN-1:0]  stop_pc;
    logic [XLEN-1:0]  pc_d;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_data;
    logic             rd_valid;
    logic             rd_ready;
    logic             rd_kind;
    logic [CYC_W-1:0] rd_cyc;
    logic [XLEN-1:0]  rd_addr;
    logic [XLEN-1:0]  rd_data;
    logic [1:0]       state;
    logic [15:0]      lost_cnt;

    modport master (
        output arm, stop_pc, pc_d, wb_we, wb_rd, wb_data,
               mem_we, mem_addr, mem_data, rd_ready,
        input  rd_valid, rd_kind, rd_cyc, rd_addr, rd_data, state, lost_cnt
    );

    modport slave (
        input  arm, stop_pc, pc_d, wb_we, wb_rd, wb_data,
               mem_we, mem_addr, mem_data, rd_ready,
        output rd_valid, rd_kind, rd_cyc, rd_addr, rd_data, state, lost_cnt
    );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retire trace unit: records register write-backs and stores, each with a cycle
// stamp, into a ring. Capture stops after a PC match plus a post-trigger window.
// The ring then drains oldest-first over a valid/ready port.
module retire_trace_buffer #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 16,
    parameter int POST_CNT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    retire_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(POST_CNT + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic             kind;
        logic [CYC_W-1:0] cyc;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
    } entry_t;

    entry_t ring [DEPTH];

    logic [1:0]       state_q,    state_n;
    logic [AW-1:0]    rptr_q,     rptr_n;
    logic [AW-1:0]    wptr_q,     wptr_n;
    logic [CW-1:0]    count_q,    count_n;
    logic [CYC_W-1:0] cyc_q,      cyc_n;
    logic [PW-1:0]    post_q,     post_n;
    logic [15:0]      lost_q,     lost_n;
    logic             rd_valid_q, rd_valid_n;
    entry_t           hold_q;
    entry_t           head;

    logic          reg_ev, st_ev, capture, pop;
    logic [CW-1:0] n_new, free_slots, over;
    logic [AW-1:0] st_idx;
    logic [16:0]   lost_sum;

    assign reg_ev     = bus.wb_we && (bus.wb_rd != 5'd0);
    assign st_ev      = bus.mem_we;
    assign capture    = !bus.arm && (state_q == S_ARMED || state_q == S_POST);
    assign n_new      = capture ? (CW'(reg_ev) + CW'(st_ev)) : '0;
    assign free_slots = CW'(DEPTH) - count_q;
    // Entries that land on an occupied slot push the oldest entry out.
    assign over       = (n_new > free_slots) ? (n_new - free_slots) : '0;
    assign st_idx     = wptr_q + AW'(reg_ev);
    assign lost_sum   = {1'b0, lost_q} + 17'(over);
    assign pop        = (state_q == S_DONE) && rd_valid_q && bus.rd_ready;

    // Next-state, pointer, counter and lost-count computation.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_n = state_q;
        rptr_n  = rptr_q;
        wptr_n  = wptr_q;
        count_n = count_q;
        cyc_n   = cyc_q;
        post_n  = post_q;
        lost_n  = lost_q;
        if (bus.arm) begin
            state_n = S_ARMED;
            rptr_n  = '0;
            wptr_n  = '0;
            count_n = '0;
            cyc_n   = '0;
            post_n  = '0;
            lost_n  = '0;
        end else begin
            case (state_q)
                S_ARMED, S_POST: begin
                    cyc_n   = cyc_q + 1'b1;
                    wptr_n  = wptr_q + AW'(n_new);
                    rptr_n  = rptr_q + AW'(over);
                    count_n = count_q + n_new - over;
                    lost_n  = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
                    if (state_q == S_ARMED) begin
                        if (bus.pc_d == bus.stop_pc) begin
                            if (POST_CNT == 0) begin
                                state_n = S_DONE;
                            end else begin
                                state_n = S_POST;
                                post_n  = PW'(POST_CNT);
                            end
                        end
                    end else begin
                        post_n = post_q - 1'b1;
                        if (post_q <= PW'(1)) begin
                            state_n = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (pop) begin
                        rptr_n  = rptr_q + 1'b1;
                        count_n = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
        rd_valid_n = (state_n == S_DONE) && (count_n != '0);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst) begin
            state_q    <= S_IDLE;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            post_q     <= '0;
            lost_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            rptr_q     <= rptr_n;
            wptr_q     <= wptr_n;
            count_q    <= count_n;
            cyc_q      <= cyc_n;
            post_q     <= post_n;
            lost_q     <= lost_n;
            rd_valid_q <= rd_valid_n;
        end
    end

    // Ring write port. A register event goes at wptr, and a same-cycle store goes right after it.
    always_ff @(posedge clk) begin
        // NOTE: ring storage is deliberately not reset; count and pointers alone define what is valid.
        if (capture) begin
            if (reg_ev) begin
                ring[wptr_q] <= {1'b0, cyc_q, XLEN'(bus.wb_rd), bus.wb_data};
            end
            if (st_ev) begin
                ring[st_idx] <= {1'b1, cyc_q, bus.mem_addr, bus.mem_data};
            end
        end
    end

    // Remember the entry being popped so the read port holds it once the ring is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= ring[rptr_q];
        end
    end

    assign head         = rd_valid_q ? ring[rptr_q] : hold_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_kind  = head.kind;
    assign bus.rd_cyc   = head.cyc;
    assign bus.rd_addr  = head.addr;
    assign bus.rd_data  = head.data;
    assign bus.state    = state_q;
    assign bus.lost_cnt = lost_q;
endmodule
